// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// ---------------------------------------------------------------------------
// Registered RISC-V ALU control decoder for the X-RISC core.
//
// Decodes the ALUOp class from the main decoder, together with the
// instruction fields funct3, opcode bit 5 and funct7 bit 5, into the 3-bit
// ALU operation select. The result is registered, so it appears one clock
// after the inputs are sampled. Unsupported encodings decode to 000 with
// the illegal flag set, so the outputs always carry a defined value.
//
// Build option:
//   ALU_DEC_EXT_EN  - when defined, the spare ALUOp=10 funct3 codes decode
//                     to xor (100), sll (001) and srl (101 with funct7b5=0).
//                     sra and sltu stay illegal. When undefined, these
//                     codes are illegal.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   in_valid    in   decode inputs valid this cycle
//   ALUOp[1:0]  in   operation class from the main decoder
//   funct3[2:0] in   instruction bits [14:12]
//   opb5        in   opcode bit 5 (1 = R-type, 0 = I-type)
//   funct7b5    in   instruction bit 30
//   ALUControl  out  registered ALU operation select
//   out_valid   out  ALUControl/illegal hold a fresh decode
//   illegal     out  captured inputs were an unsupported encoding
// ---------------------------------------------------------------------------
module alu_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       opb5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl,
    output logic       out_valid,
    output logic       illegal
);

    // ALU operation select encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // ALUOp classes
    localparam logic [1:0] OP_MEM    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_ARITH  = 2'b10;

    // funct3 codes under the arithmetic class
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
`ifdef ALU_DEC_EXT_EN
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
`endif

    logic [2:0] dec_ctrl;
    logic       dec_illegal;

    logic [2:0] ctrl_d,    ctrl_q;
    logic       illegal_d, illegal_q;
    logic       valid_d,   valid_q;

    // ------------------------------------------------------------------
    // Combinational decode. Every path that is not an explicitly supported
    // encoding falls to a default arm producing 000 + illegal, which also
    // catches unknown select values in simulation.
    // ------------------------------------------------------------------
    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_illegal = 1'b0;
        case (ALUOp)
            OP_MEM: begin
                dec_ctrl = ALU_ADD;
            end
            OP_BRANCH: begin
                dec_ctrl = ALU_SUB;
            end
            OP_ARITH: begin
                case (funct3)
                    F3_ADD: begin
                        // Only the R-type form with funct7b5 set is sub;
                        // addi ignores bit 30 since it is immediate data.
                        if (opb5 & funct7b5) begin
                            dec_ctrl = ALU_SUB;
                        end else begin
                            dec_ctrl = ALU_ADD;
                        end
                    end
                    F3_SLT: dec_ctrl = ALU_SLT;
                    F3_OR:  dec_ctrl = ALU_OR;
                    F3_AND: dec_ctrl = ALU_AND;
`ifdef ALU_DEC_EXT_EN
                    F3_XOR: dec_ctrl = ALU_XOR;
                    F3_SLL: dec_ctrl = ALU_SLL;
                    F3_SR: begin
                        // srl is supported; sra (funct7b5=1) is not.
                        if (!funct7b5) begin
                            dec_ctrl = ALU_SRL;
                        end else begin
                            dec_ctrl    = ALU_ADD;
                            dec_illegal = 1'b1;
                        end
                    end
`endif
                    default: begin
                        dec_ctrl    = ALU_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_ctrl    = ALU_ADD;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register next-state: capture on in_valid, otherwise hold the
    // last decode while out_valid drops.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        valid_d   = in_valid;
        if (in_valid) begin
            ctrl_d    = dec_ctrl;
            illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= ALU_ADD;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
        end
    end

    assign ALUControl = ctrl_q;
    assign illegal    = illegal_q;
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_alu_decoder.sv
// ---------------------------------------------------------------------------
// tb_alu_decoder
// ---------------------------------------------------------------------------
// Self-checking bench for alu_decoder. A reference model built from an
// instruction-mnemonic table predicts the registered outputs every cycle;
// each scenario task compares {ALUControl, illegal, out_valid} against it.
// Define ALU_DEC_EXT_EN for both the bench and the design to check the
// extended decode.
// ---------------------------------------------------------------------------
module tb_alu_decoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic       opb5;
    logic       funct7b5;
    logic [2:0] ALUControl;
    logic       out_valid;
    logic       illegal;

    int n_cmp;
    int n_fail;

    // Expected {ALUControl, illegal, out_valid}
    logic [4:0] exp_out;
    logic [4:0] act_out;

    // Per-funct3 result for ALUOp=10: {illegal, ctrl}. funct3=000 and the
    // shift-right code depend on other bits and are handled in ref_decode.
    logic [3:0] arith_tbl [8];

    alu_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .opb5       (opb5),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act_out = {ALUControl, illegal, out_valid};

    // Returns {illegal, ctrl}
    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                              input logic b5, input logic f7);
        if (op == 2'd0) return 4'b0_000;      // lw/sw address add
        if (op == 2'd1) return 4'b0_001;      // beq subtract
        if (op == 2'd3) return 4'b1_000;
        if (f3 == 3'd0) return (b5 && f7) ? 4'b0_001 : 4'b0_000;
`ifdef ALU_DEC_EXT_EN
        if (f3 == 3'd5) return f7 ? 4'b1_000 : 4'b0_111;
`endif
        return arith_tbl[f3];
    endfunction

    // Advance one clock while updating the model from the inputs that the
    // DUT samples at that edge; returns 1 ns after the edge.
    task automatic tick();
        logic [3:0] r;
        r = ref_decode(ALUOp, funct3, opb5, funct7b5);
        if (reset)         exp_out = 5'b000_0_0;
        else if (in_valid) exp_out = {r[2:0], r[3], 1'b1};
        else               exp_out = {exp_out[4:1], 1'b0};
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic b5, input logic f7);
        in_valid = v;
        ALUOp    = op;
        funct3   = f3;
        opb5     = b5;
        funct7b5 = f7;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            tick();
            n_cmp++;
            if (act_out !== 5'b000_0_0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got ctrl/ill/vld=%b req=00000", i, act_out);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            tick();
            n_cmp++;
            if (act_out !== 5'b000_0_0) begin
                n_fail++;
                $display("FAIL reset_release_idle[%0d]: got %b req=00000", i, act_out);
            end
        end
    endtask

    task automatic test_fixed_classes();
        for (int i = 0; i < 6; i++) begin
            logic [1:0] op;
            op = (i % 2 == 0) ? 2'd0 : 2'd1;
            drive(1'b1, op, 3'($urandom), 1'($urandom), 1'($urandom));
            tick();
            n_cmp++;
            if (act_out !== exp_out || act_out !== {(op == 2'd0) ? 3'b000 : 3'b001, 2'b01}) begin
                n_fail++;
                $display("FAIL fixed_class op=%b: got %b req=%b", op, act_out, exp_out);
            end
        end
    endtask

    task automatic test_arith();
        // {opb5, funct7b5, expected ctrl}
        logic [4:0] vec [4];
        vec[0] = {1'b1, 1'b1, 3'b001};   // sub
        vec[1] = {1'b0, 1'b0, 3'b000};   // addi
        vec[2] = {1'b0, 1'b1, 3'b000};   // addi with bit 30 set
        vec[3] = {1'b1, 1'b0, 3'b000};   // add
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd2, 3'd0, vec[i][4], vec[i][3]);
            tick();
            n_cmp++;
            if (act_out !== {vec[i][2:0], 2'b01}) begin
                n_fail++;
                $display("FAIL arith_f3_000[%0d]: got %b req=%b", i, act_out, {vec[i][2:0], 2'b01});
            end
        end
    endtask

    task automatic test_back_to_back();
        // slt, or, and in consecutive cycles, one result per cycle
        logic [2:0] f3s [3];
        logic [2:0] res [3];
        f3s[0] = 3'b010; res[0] = 3'b101;
        f3s[1] = 3'b110; res[1] = 3'b011;
        f3s[2] = 3'b111; res[2] = 3'b010;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd2, f3s[i], 1'($urandom), 1'($urandom));
            tick();
            n_cmp++;
            if (act_out !== {res[i], 2'b01}) begin
                n_fail++;
                $display("FAIL b2b_logic f3=%b: got %b req=%b", f3s[i], act_out, {res[i], 2'b01});
            end
        end
    endtask

    task automatic test_illegal();
        logic [4:0] req;
        drive(1'b1, 2'd3, 3'($urandom), 1'($urandom), 1'($urandom));
        tick();
        n_cmp++;
        if (act_out !== 5'b000_1_1) begin
            n_fail++;
            $display("FAIL illegal_aluop11: got %b req=00011", act_out);
        end
        drive(1'b1, 2'd2, 3'b100, 1'b1, 1'b0);
        tick();
`ifdef ALU_DEC_EXT_EN
        req = 5'b100_0_1;
`else
        req = 5'b000_1_1;
`endif
        n_cmp++;
        if (act_out !== req) begin
            n_fail++;
            $display("FAIL f3_100: got %b req=%b", act_out, req);
        end
        drive(1'b1, 2'd2, 3'b101, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if (act_out !== 5'b000_1_1) begin
            n_fail++;
            $display("FAIL sra_illegal: got %b req=00011", act_out);
        end
        drive(1'b1, 2'd2, 3'b011, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (act_out !== 5'b000_1_1) begin
            n_fail++;
            $display("FAIL sltu_illegal: got %b req=00011", act_out);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 2'd2, 3'b110, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (act_out !== 5'b011_0_1) begin
            n_fail++;
            $display("FAIL hold_capture_or: got %b req=01101", act_out);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            tick();
            n_cmp++;
            if (act_out !== 5'b011_0_0) begin
                n_fail++;
                $display("FAIL hold_idle[%0d]: got %b req=01100", i, act_out);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 2'd2, 3'b000, 1'b1, 1'b1);   // valid sub, killed by reset
        reset = 1'b1;
        tick();
        n_cmp++;
        if (act_out !== 5'b000_0_0) begin
            n_fail++;
            $display("FAIL reset_midstream: got %b req=00000", act_out);
        end
        reset = 1'b0;
        drive(1'b1, 2'd2, 3'b010, 1'b0, 1'b0);   // first valid after reset: slt
        tick();
        n_cmp++;
        if (act_out !== 5'b101_0_1) begin
            n_fail++;
            $display("FAIL first_after_reset: got %b req=10101", act_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 19) == 0);
            drive(($urandom_range(0, 9) < 7), 2'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom));
            tick();
            n_cmp++;
            if (act_out !== exp_out) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b req=%b", i, act_out, exp_out);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        exp_out = 5'b0;
        for (int i = 0; i < 8; i++) arith_tbl[i] = 4'b1_000;
        arith_tbl[2] = 4'b0_101;   // slt
        arith_tbl[6] = 4'b0_011;   // or
        arith_tbl[7] = 4'b0_010;   // and
`ifdef ALU_DEC_EXT_EN
        arith_tbl[4] = 4'b0_100;   // xor
        arith_tbl[1] = 4'b0_110;   // sll
`endif
        reset = 1'b1;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
        #1;

        test_reset();
        test_fixed_classes();
        test_arith();
        test_back_to_back();
        test_illegal();
        test_hold();
        test_reset_midstream();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
